mem_serial_ctrl: RTL
====================

# mem_serial_ctrl

Sequencer between the narrow serial pin interface and the on-chip memory array under test. It assembles a command (read/write flag, address, write data) from `SERIAL_BITS`-wide input beats, drives the array's address/write-enable/write-data with the timing required by the storage element, and serializes read data back out. It sits inside `tt_um_toivoh_on_chip_memory_test`, between the pin mux and the memory instance.

## Interface
- `ADDR_BITS`, default 6: memory address width; must be a multiple of `SERIAL_BITS`.
- `DATA_BITS`, default 8: memory word width; must be a multiple of `SERIAL_BITS`.
- `SERIAL_BITS`, default 2: beat width on the serial in/out links.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  SERIAL_BITS  command beat.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  controller accepts a beat this cycle.
- `out_data`  out  SERIAL_BITS  read-data beat.
- `out_valid`  out  1  `out_data` is valid this cycle; there is no backpressure.
- `mem_addr`  out  ADDR_BITS  array address, registered.
- `mem_we`  out  1  array write enable, registered.
- `mem_wdata`  out  DATA_BITS  array write data, registered.
- `mem_rdata`  in  DATA_BITS  array read data; combinational from `mem_addr`.

## Operation
- A beat is accepted when `in_valid && in_ready`. A cycle with `in_valid` low is a stall: no timeout, and state is held.
- Frame layout:
  - Header: 1 beat. Bit 0 is the write flag; other bits are ignored.
  - Address: `ADDR_BITS/SERIAL_BITS` beats, LSB first.
  - Data: `DATA_BITS/SERIAL_BITS` beats, LSB first, present only for writes.
- States: HDR (idle, waiting for a header), ADDR, DATA, PRE, WR, POST, RD, OUT.
  - HDR -> ADDR when a header is accepted.
  - ADDR -> DATA (write) or RD (read) when the last address beat is accepted.
  - DATA -> PRE when the last data beat is accepted. With the guard compiled out, DATA -> WR instead.
  - PRE -> WR -> POST -> HDR, each in one cycle. With the guard compiled out, WR -> HDR.
  - RD -> OUT after one cycle. OUT -> HDR after the last output beat.
- `in_ready` is 1 in HDR, ADDR and DATA; it is 0 in every other state.
- Address and data are shifted into holding registers as beats arrive. `mem_addr` and `mem_wdata` are loaded from these registers on entry to PRE, WR or RD, and hold their value until the next command loads them.
- `mem_we` is 1 only in WR.
- In RD, `mem_rdata` is captured into a shift register at the end of the cycle. In OUT it is shifted out LSB first, one beat per cycle, with `out_valid` high.
- Beat counter width is `$clog2` of the maximum beat count. The counter is cleared on every state change.

## Timing
- Reset, applied on a clock edge with `rst_n` low: state = HDR, all counters = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `out_valid` = 0, `out_data` = 0, `in_ready` = 1 in the first cycle after reset.
- Reset in the middle of a command aborts it; the partial frame is discarded. Reset during WR drops `mem_we` to 0 on that edge.
- Write, last data beat accepted in cycle N:
  - Guard on: PRE in N+1 (address and data stable, `mem_we` = 0), WR in N+2, POST in N+3, `in_ready` = 1 in N+4.
  - Guard off: WR in N+1, `in_ready` = 1 in N+2.
- Read, last address beat accepted in cycle N: `mem_addr` is valid in N+1 (RD). Output beats come in N+2 .. N+1+`DATA_BITS/SERIAL_BITS`. `in_ready` = 1 in the cycle after the last beat.
- `in_valid` while `in_ready` = 0 is ignored; no beat is lost from a frame in progress.
- Back-to-back commands: a header can be accepted in the first cycle `in_ready` returns to 1.

## Configuration
- `MEM_CTRL_WRITE_GUARD_EN` defined: the PRE and POST states exist. Address and data are held stable for one cycle before and one cycle after the `mem_we` pulse; this is required for latch-based (DLXTP) arrays. A write costs 3 cycles.
- Not defined: PRE and POST are removed and a write costs 1 cycle. This is for flop-based arrays.

## Test plan
- Reset: hold `rst_n` low for 2 cycles with `in_valid` = 1 -> `mem_we` = 0, `out_valid` = 0, `mem_addr` = 0, `in_ready` = 1 after release.
- Write addr 0x2A, data 0xC3: send beats 1, 2, 2, 2, 3, 0, 0, 3 -> one `mem_we` pulse with `mem_addr` = 0x2A and `mem_wdata` = 0xC3.
  - Guard on: `mem_addr` and `mem_wdata` are stable in the cycles before and after the pulse.
  - Guard off: the pulse is in the cycle after the last beat.
- Read addr 0x2A after that write: send beats 0, 2, 2, 2 -> `mem_addr` = 0x2A in the next cycle, then `out_data` beats 3, 0, 0, 3 with `out_valid` high for exactly 4 cycles.
- Stalls and ignored beats: during a write, insert `in_valid` = 0 gaps of 0–3 cycles between beats, and drive `in_valid` = 1 with garbage while `in_ready` = 0 -> results identical to the gapless case.
- Reset mid-frame: reset after 2 address beats, then send a full read of addr 0 -> no write occurs, and the read returns the contents of addr 0.
- Back-to-back: write every address with `addr ^ 0x5A`, then read all addresses back -> every read matches, and each header is accepted in the first cycle `in_ready` is 1.

Source files
------------

// File: rtl/mem_serial_ctrl.sv
// Serial command sequencer for the on-chip memory array: beats in, timed array access, beats out.
// Optional MEM_CTRL_WRITE_GUARD_EN adds PRE/POST hold cycles around the write pulse for latch arrays.
module mem_serial_ctrl #(
   parameter int ADDR_BITS   = 6,
   parameter int DATA_BITS   = 8,
   parameter int SERIAL_BITS = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [SERIAL_BITS-1:0] in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [SERIAL_BITS-1:0] out_data,
   output logic                   out_valid,
   output logic [ADDR_BITS-1:0]   mem_addr,
   output logic                   mem_we,
   output logic [DATA_BITS-1:0]   mem_wdata,
   input  logic [DATA_BITS-1:0]   mem_rdata,
   output logic [2:0]             dbg_state
);

   localparam int A_BEATS   = ADDR_BITS / SERIAL_BITS;
   localparam int D_BEATS   = DATA_BITS / SERIAL_BITS;
   localparam int MAX_BEATS = (A_BEATS > D_BEATS) ? A_BEATS : D_BEATS;
   localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_BEATS - 1);
   localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_BEATS - 1);

   typedef enum logic [2:0] {
      S_HDR  = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
`ifdef MEM_CTRL_WRITE_GUARD_EN
      S_PRE  = 3'd3,
      S_POST = 3'd5,
`endif
      S_WR   = 3'd4,
      S_RD   = 3'd6,
      S_OUT  = 3'd7
   } state_t;

   // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
   // out_valid marks a read beat and has no ready (the receiver must take it).
   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic                   wr_flag;
   logic [ADDR_BITS-1:0]   addr_sr, addr_shift;
   logic [DATA_BITS-1:0]   data_sr, data_shift, rd_sr;
   logic                   accept, last_addr, last_data, load_mem;

   always_comb begin
      state_nxt  = state;
      in_ready   = (state == S_HDR) || (state == S_ADDR) || (state == S_DATA);
      accept     = in_valid && in_ready;
      addr_shift = {in_data, addr_sr[ADDR_BITS-1:SERIAL_BITS]};
      data_shift = {in_data, data_sr[DATA_BITS-1:SERIAL_BITS]};
      last_addr  = accept && (state == S_ADDR) && (cnt == A_LAST);
      last_data  = accept && (state == S_DATA) && (cnt == D_LAST);
      // Array-side registers take the completed command, including the beat arriving now.
      load_mem   = (last_addr && !wr_flag) || last_data;
      out_valid  = (state == S_OUT);
      out_data   = out_valid ? rd_sr[SERIAL_BITS-1:0] : '0;
      dbg_state  = state;
      case (state)
         S_HDR:  if (accept) state_nxt = S_ADDR;
         S_ADDR: if (last_addr) state_nxt = wr_flag ? S_DATA : S_RD;
`ifdef MEM_CTRL_WRITE_GUARD_EN
         S_DATA: if (last_data) state_nxt = S_PRE;
         S_PRE:  state_nxt = S_WR;
         S_WR:   state_nxt = S_POST;
         S_POST: state_nxt = S_HDR;
`else
         S_DATA: if (last_data) state_nxt = S_WR;
         S_WR:   state_nxt = S_HDR;
`endif
         S_RD:   state_nxt = S_OUT;
         S_OUT:  if (cnt == D_LAST) state_nxt = S_HDR;
         default: state_nxt = S_HDR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_HDR;
         cnt       <= '0;
         wr_flag   <= 1'b0;
         addr_sr   <= '0;
         data_sr   <= '0;
         rd_sr     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            cnt <= '0;
         else if (accept || (state == S_OUT))
            cnt <= cnt + 1'b1;
         if ((state == S_HDR) && accept) wr_flag <= in_data[0];
         if ((state == S_ADDR) && accept) addr_sr <= addr_shift;
         if ((state == S_DATA) && accept) data_sr <= data_shift;
         if (state == S_RD)
            rd_sr <= mem_rdata;
         else if (state == S_OUT)
            rd_sr <= rd_sr >> SERIAL_BITS;
         if (load_mem) begin
            mem_addr  <= (state == S_ADDR) ? addr_shift : addr_sr;
            mem_wdata <= (state == S_DATA) ? data_shift : data_sr;
         end
         mem_we <= (state_nxt == S_WR);
      end
   end

endmodule
